// File: rtl/dec4_rr_grant_ctrl.sv
// Round-robin owner sequencer for a shared 2x4 active-low decoder channel.
// It bounds the hold time per owner and inserts a dead-time gap between owners.
module dec4_rr_grant_ctrl #(
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    output logic       o_dec_a,
    output logic       o_dec_b,
    output logic       o_dec_e,
    output logic [3:0] o_grant_n,
    output logic [1:0] o_owner,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          r_state,   w_state;
    logic [1:0]      r_ptr,     w_ptr;
    logic [HW-1:0]   r_hold,    w_hold;
    logic [3:0]      r_gap,     w_gap;
    logic [1:0]      r_owner,   w_owner;
    logic [3:0]      r_grant_n, w_grant_n;
    logic            r_dec_a,   w_dec_a;
    logic            r_dec_b,   w_dec_b;
    logic            r_dec_e,   w_dec_e;
    logic            r_busy,    w_busy;
    logic            r_timeout, w_timeout;
    logic [1:0]      w_win;
    logic            w_owner_req;

    // First requester at or after ptr, wrapping modulo 4; the lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        win = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                win = idx;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    assign w_win       = rr_pick(i_req, r_ptr);
    assign w_owner_req = i_req[r_owner];

    // Next-state and next-output logic.
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_hold    = r_hold;
        w_gap     = r_gap;
        w_owner   = r_owner;
        w_grant_n = r_grant_n;
        w_dec_a   = r_dec_a;
        w_dec_b   = r_dec_b;
        w_dec_e   = r_dec_e;
        w_busy    = r_busy;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req) begin
                    w_state   = ST_GRANT;
                    w_owner   = w_win;
                    w_grant_n = ~(4'b0001 << w_win);
                    // Decoder maps {b,a}: 11->0, 01->1, 10->2, 00->3.
                    w_dec_a   = ~w_win[1];
                    w_dec_b   = ~w_win[0];
                    w_dec_e   = 1'b0;
                    w_busy    = 1'b1;
                    w_hold    = HW'(1);
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req || (r_hold == HW'(MAX_HOLD))) begin
                    w_state   = ST_GAP;
                    w_ptr     = r_owner + 2'd1;
                    w_grant_n = 4'b1111;
                    w_dec_e   = 1'b1;
                    w_busy    = 1'b0;
                    w_hold    = HW'(0);
                    w_gap     = 4'd1;
                    w_timeout = w_owner_req;
                end else begin
                    w_hold = r_hold + HW'(1);
                end
            end
            ST_GAP: begin
                if (r_gap >= 4'(GAP_CYCLES)) begin
                    w_state = ST_IDLE;
                    w_gap   = 4'd0;
                end else begin
                    w_gap = r_gap + 4'd1;
                end
            end
            default: begin
                w_state   = ST_IDLE;
                w_grant_n = 4'b1111;
                w_dec_e   = 1'b1;
                w_busy    = 1'b0;
                w_hold    = HW'(0);
                w_gap     = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_hold    <= HW'(0);
            r_gap     <= 4'd0;
            r_owner   <= 2'd0;
            r_grant_n <= 4'b1111;
            r_dec_a   <= 1'b0;
            r_dec_b   <= 1'b0;
            r_dec_e   <= 1'b1;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_hold    <= w_hold;
            r_gap     <= w_gap;
            r_owner   <= w_owner;
            r_grant_n <= w_grant_n;
            r_dec_a   <= w_dec_a;
            r_dec_b   <= w_dec_b;
            r_dec_e   <= w_dec_e;
            r_busy    <= w_busy;
            r_timeout <= w_timeout;
        end
    end

    assign o_dec_a   = r_dec_a;
    assign o_dec_b   = r_dec_b;
    assign o_dec_e   = r_dec_e;
    assign o_grant_n = r_grant_n;
    assign o_owner   = r_owner;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_dec4_rr_grant_ctrl.sv
// Directed bench for dec4_rr_grant_ctrl (MAX_HOLD=4, GAP_CYCLES=1).
// Observed vector: {grant_n, dec_e, busy, timeout, owner, dec_b, dec_a}.
module tb_dec4_rr_grant_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       dec_a;
    logic       dec_b;
    logic       dec_e;
    logic [3:0] grant_n;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int n_cmp;
    int n_err;

    localparam logic [10:0] RST_V = {4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00};

    dec4_rr_grant_ctrl #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .o_dec_a   (dec_a),
        .o_dec_b   (dec_b),
        .o_dec_e   (dec_e),
        .o_grant_n (grant_n),
        .o_owner   (owner),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] sel(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'b11;
            2'd1:    return 2'b01;
            2'd2:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] gn(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [10:0] gv(input logic [1:0] idx);
        return {gn(idx), 1'b0, 1'b1, 1'b0, idx, sel(idx)};
    endfunction

    function automatic logic [10:0] iv(input logic [1:0] idx, input logic to);
        return {4'b1111, 1'b1, 1'b0, to, idx, sel(idx)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {grant_n, dec_e, busy, timeout, owner, dec_b, dec_a};
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] idx;
        n_cmp = 0;
        n_err = 0;

        // Reset with every requester active.
        rst = 1'b1;
        req = 4'b1111;
        tick(); chk("rst_1", RST_V);
        tick(); chk("rst_2", RST_V);

        // Single requester 0, three grant cycles, then release.
        rst = 1'b0;
        req = 4'b0001;
        tick(); chk("t2_g1", gv(2'd0));
        tick(); chk("t2_g2", gv(2'd0));
        tick(); chk("t2_g3", gv(2'd0));
        req = 4'b0000;
        tick(); chk("t2_gap", iv(2'd0, 1'b0));
        tick(); chk("t2_idle", iv(2'd0, 1'b0));

        // All request; pointer is 1 so owners rotate 1,2,3,0,1.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            idx = 2'(k + 1);
            tick(); chk("t3_g1", gv(idx));
            tick(); chk("t3_g2", gv(idx));
            req = 4'b1111 & ~(4'b0001 << idx);
            tick(); chk("t3_gap", iv(idx, 1'b0));
            req = 4'b1111;
            tick(); chk("t3_idle", iv(idx, 1'b0));
        end

        // Requester 2 holds forever: force release after 4 cycles, then re-grant.
        req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick(); chk("t4_hold", gv(2'd2));
        end
        tick(); chk("t4_timeout", iv(2'd2, 1'b1));
        tick(); chk("t4_idle", iv(2'd2, 1'b0));
        tick(); chk("t4_regrant", gv(2'd2));

        // Release in the 4th grant cycle coincides with MAX_HOLD: no timeout.
        tick(); chk("t5_g2", gv(2'd2));
        tick(); chk("t5_g3", gv(2'd2));
        tick(); chk("t5_g4", gv(2'd2));
        req = 4'b0000;
        tick(); chk("t5_release", iv(2'd2, 1'b0));
        tick(); chk("t5_idle", iv(2'd2, 1'b0));

        // Pointer is 3; requester 1 wins, then reset mid-grant.
        req = 4'b0010;
        tick(); chk("t6_g1", gv(2'd1));
        tick(); chk("t6_g2", gv(2'd1));
        rst = 1'b1;
        req = 4'b1010;
        tick(); chk("t6_rst", RST_V);
        rst = 1'b0;
        tick(); chk("t6_ptr0_pick", gv(2'd1));
        tick(); chk("t6_g2b", gv(2'd1));

        req = 4'b0000;
        tick(); chk("t6_release", iv(2'd1, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
